// File: rtl/wb_mem_slave.sv
// wb_mem_slave: Wishbone classic slave backed by a byte-lane-writable word memory.
// Ports:
//   clk, reset                 single clock, synchronous active-high reset
//   wb_cyc_i, wb_stb_i         request qualifiers from the master
//   wb_we_i                    1 = write, 0 = read
//   wb_adr_i                   byte address
//   wb_dat_i, wb_sel_i         write data and byte-lane enables
//   wb_dat_o                   read data, held until the next valid read
//   wb_ack_o, wb_err_o         registered one-cycle completion strobes
module wb_mem_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          ADDR_WIDTH  = 32,
    parameter int          DATA_WIDTH  = 32,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_STATES = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wb_cyc_i,
    input  logic                    wb_stb_i,
    input  logic                    wb_we_i,
    input  logic [ADDR_WIDTH-1:0]   wb_adr_i,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    output logic                    wb_ack_o,
    output logic                    wb_err_o
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int IW = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_WIDTH-1:0] BASE  = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] DEPTH = ADDR_WIDTH'(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                state_q, state_d;
    logic [3:0]            wait_cnt_q, wait_cnt_d;
    logic [ADDR_WIDTH-1:0] adr_q, adr_d;
    logic                  we_q, we_d;
    logic [NB-1:0]         sel_q, sel_d;
    logic [DATA_WIDTH-1:0] dat_q, dat_d;
    logic [DATA_WIDTH-1:0] dat_o_q, dat_o_d;
    logic                  ack_q, ack_d, err_q, err_d;
    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];
    logic [ADDR_WIDTH-1:0] offset, word_idx;
    logic                  valid, mem_we;

    // Below-base addresses wrap to huge offsets, so the explicit >= test is kept
    // alongside the depth test to reject them regardless of BASE_ADDR.
    assign offset   = adr_q - BASE;
    assign word_idx = offset >> 2;
    assign valid    = adr_q >= BASE && word_idx < DEPTH && adr_q[1:0] == 2'b00;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        adr_d      = adr_q;
        we_d       = we_q;
        sel_d      = sel_q;
        dat_d      = dat_q;
        dat_o_d    = dat_o_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        mem_we     = 1'b0;
        case (state_q)
            IDLE: if (wb_cyc_i && wb_stb_i) begin
                adr_d      = wb_adr_i;
                we_d       = wb_we_i;
                sel_d      = wb_sel_i;
                dat_d      = wb_dat_i;
                wait_cnt_d = 4'(WAIT_STATES);
                state_d    = WAIT;
            end
            WAIT: begin
                // A dropped request at any WAIT edge abandons the access silently.
                if (!(wb_cyc_i && wb_stb_i)) state_d = IDLE;
                else if (wait_cnt_q != 4'd0) wait_cnt_d = wait_cnt_q - 4'd1;
                else begin
                    state_d = RESP;
                    ack_d   = valid;
                    err_d   = !valid;
                    mem_we  = valid && we_q;
                    dat_o_d = (valid && !we_q) ? mem[word_idx[IW-1:0]] : dat_o_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            adr_q      <= '0;
            we_q       <= 1'b0;
            sel_q      <= '0;
            dat_q      <= '0;
            dat_o_q    <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            adr_q      <= adr_d;
            we_q       <= we_d;
            sel_q      <= sel_d;
            dat_q      <= dat_d;
            dat_o_q    <= dat_o_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
        end
    end

    // Memory is never cleared; reset only blocks a write landing on the same edge.
    always_ff @(posedge clk) begin
        if (mem_we && !reset)
            for (int b = 0; b < NB; b++)
                if (sel_q[b]) mem[word_idx[IW-1:0]][8*b +: 8] <= dat_q[8*b +: 8];
    end

    assign wb_dat_o = dat_o_q;
    assign wb_ack_o = ack_q;
    assign wb_err_o = err_q;
endmodule

// File: tb/tb_wb_mem_slave.sv
// tb_wb_mem_slave: scoreboard bench for wb_mem_slave across several wait-state settings.
module tb_wb_mem_slave;
    typedef struct { bit err; logic [31:0] dat; int lat; } exp_t;
    typedef struct { int d; bit w; logic [31:0] a; logic [31:0] v; logic [3:0] s; } op_t;

    logic        clk = 1'b0, reset = 1'b1;
    logic [3:0]  cyc = '0;
    logic        stb = 1'b0, we = 1'b0;
    logic [31:0] adr = '0, wdat = '0;
    logic [3:0]  sel = '0;
    logic [31:0] dat_o [4];
    logic        ack [4], err [4];

    int checks = 0, errors = 0, resp_seen = 0, resp_exp = 0;
    exp_t sb[$];
    logic [31:0] mm [int];
    logic [31:0] mdo [4] = '{default: '0};
    bit          r_got;
    int          r_lat;
    logic        r_ack, r_err, r_tail;
    logic [31:0] r_dat;

    always #5 clk = ~clk;

    // Instance d uses wait states 1, 3, 0, 15; only the selected instance sees cyc.
    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int W = g == 0 ? 1 : g == 1 ? 3 : g == 2 ? 0 : 15;
        wb_mem_slave #(.WAIT_STATES(W)) dut (
            .clk(clk), .reset(reset), .wb_cyc_i(cyc[g]), .wb_stb_i(stb), .wb_we_i(we),
            .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel),
            .wb_dat_o(dat_o[g]), .wb_ack_o(ack[g]), .wb_err_o(err[g])
        );
    end

    function automatic int ws(int d);
        return d == 0 ? 1 : d == 1 ? 3 : d == 2 ? 0 : 15;
    endfunction

    function automatic bit ok_adr(logic [31:0] a);
        return a >= 32'h8000_0000 && a <= 32'h8000_0ffc && a[1:0] == 2'b00;
    endfunction

    always @(negedge clk)
        for (int d = 0; d < 4; d++)
            if (ack[d] || err[d]) begin
                resp_seen++;
                checks++;
                if (ack[d] && err[d]) begin
                    errors++;
                    $display("FAIL overlap[%0d]: ack=%b err=%b, required not both high", d, ack[d], err[d]);
                end
            end

    // Update the reference model, queue the expected response, present the request.
    task automatic drive(input op_t o);
        exp_t x;
        int key;
        logic [31:0] m;
        x.err = !ok_adr(o.a);
        if (!x.err) begin
            key = o.d * 4096 + int'((o.a - 32'h8000_0000) >> 2);
            m = mm.exists(key) ? mm[key] : 'x;
            if (o.w) begin
                for (int b = 0; b < 4; b++) if (o.s[b]) m[8*b +: 8] = o.v[8*b +: 8];
                mm[key] = m;
            end else mdo[o.d] = m;
        end
        x.dat = mdo[o.d];
        x.lat = 2 + ws(o.d);
        sb.push_back(x);
        resp_exp++;
        @(negedge clk);
        cyc = 4'(1 << o.d); stb = 1'b1; we = o.w; adr = o.a; wdat = o.v; sel = o.s;
    endtask

    task automatic step(input op_t o);
        drive(o);
        r_got = 1'b0;
        r_lat = 0;
        while (!r_got && r_lat < 40) begin
            @(negedge clk);
            r_lat++;
            r_got = ack[o.d] || err[o.d];
        end
        r_ack = ack[o.d]; r_err = err[o.d]; r_dat = dat_o[o.d];
        cyc = '0; stb = 1'b0;
        @(negedge clk);
        r_tail = ack[o.d] || err[o.d];
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (ack[d] !== 1'b0 || err[d] !== 1'b0 || dat_o[d] !== 32'h0) begin
                errors++;
                $display("FAIL reset[%0d]: ack=%b err=%b dat=%h, required 0 0 00000000", d, ack[d], err[d], dat_o[d]);
            end
        end
        // Request presented on the same edge as reset must be ignored.
        cyc = 4'b0001; stb = 1'b1; we = 1'b0; adr = 32'h8000_0000;
        @(negedge clk);
        reset = 1'b0; cyc = '0; stb = 1'b0;
        begin
            int bad = 0;
            repeat (6) begin @(negedge clk); if (ack[0] || err[0]) bad++; end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL reset_req: responses=%0d, required 0", bad);
            end
        end
    endtask

    task automatic test_rw;
        op_t ops [7] = '{
            '{0, 1'b1, 32'h8000_0010, 32'hDEADBEEF, 4'hF},
            '{0, 1'b0, 32'h8000_0010, 32'h0,        4'hF},
            '{0, 1'b1, 32'h8000_0020, 32'h11223344, 4'hF},
            '{0, 1'b1, 32'h8000_0020, 32'hAABBCCDD, 4'b0101},
            '{0, 1'b0, 32'h8000_0020, 32'h0,        4'h0},
            '{0, 1'b1, 32'h8000_0020, 32'hFFFFFFFF, 4'h0},
            '{0, 1'b0, 32'h8000_0020, 32'h0,        4'h3}
        };
        for (int i = 0; i < 7; i++) begin
            exp_t x;
            step(ops[i]);
            x = sb.pop_front();
            checks++;
            if (!r_got || r_ack !== !x.err || r_err !== x.err || r_dat !== x.dat || r_lat != x.lat || r_tail !== 1'b0) begin
                errors++;
                $display("FAIL rw[%0d]: got=%b ack=%b err=%b dat=%h lat=%0d tail=%b, required ack=%b err=%b dat=%h lat=%0d tail=0",
                         i, r_got, r_ack, r_err, r_dat, r_lat, r_tail, !x.err, x.err, x.dat, x.lat);
            end
        end
        checks++;
        if (dat_o[0] !== 32'h11BB33DD) begin
            errors++;
            $display("FAIL rw_merge: dat=%h, required 11bb33dd", dat_o[0]);
        end
    endtask

    task automatic test_invalid;
        op_t ops [9] = '{
            '{0, 1'b0, 32'h8000_0010, 32'h0,        4'hF},
            '{0, 1'b0, 32'h7FFF_FFFC, 32'h0,        4'hF},
            '{0, 1'b0, 32'h8000_1000, 32'h0,        4'hF},
            '{0, 1'b0, 32'h8000_0002, 32'h0,        4'hF},
            '{0, 1'b1, 32'h8000_0011, 32'h01010101, 4'hF},
            '{0, 1'b1, 32'h8000_1000, 32'h02020202, 4'hF},
            '{0, 1'b0, 32'h8000_0010, 32'h0,        4'hF},
            '{0, 1'b1, 32'h8000_0FFC, 32'hA5A50FFC, 4'hF},
            '{0, 1'b0, 32'h8000_0FFC, 32'h0,        4'hF}
        };
        for (int i = 0; i < 9; i++) begin
            exp_t x;
            step(ops[i]);
            x = sb.pop_front();
            checks++;
            if (!r_got || r_ack !== !x.err || r_err !== x.err || r_dat !== x.dat || r_lat != x.lat || r_tail !== 1'b0) begin
                errors++;
                $display("FAIL invalid[%0d]: got=%b ack=%b err=%b dat=%h lat=%0d tail=%b, required ack=%b err=%b dat=%h lat=%0d tail=0",
                         i, r_got, r_ack, r_err, r_dat, r_lat, r_tail, !x.err, x.err, x.dat, x.lat);
            end
        end
    endtask

    task automatic test_abort;
        op_t ops [2] = '{
            '{1, 1'b1, 32'h8000_0030, 32'h01020304, 4'hF},
            '{1, 1'b0, 32'h8000_0030, 32'h0,        4'hF}
        };
        int bad = 0;
        for (int i = 0; i < 2; i++) begin
            exp_t x;
            if (i == 1) begin
                @(negedge clk);
                cyc = 4'b0010; stb = 1'b1; we = 1'b1; adr = 32'h8000_0030; wdat = 32'hFFFFFFFF; sel = 4'hF;
                @(negedge clk);
                stb = 1'b0; cyc = '0;
                repeat (25) begin @(negedge clk); if (ack[1] || err[1]) bad++; end
                checks++;
                if (bad != 0) begin
                    errors++;
                    $display("FAIL abort_resp: responses=%0d, required 0", bad);
                end
            end
            step(ops[i]);
            x = sb.pop_front();
            checks++;
            if (!r_got || r_ack !== !x.err || r_err !== x.err || r_dat !== x.dat || r_lat != x.lat || r_tail !== 1'b0) begin
                errors++;
                $display("FAIL abort[%0d]: got=%b ack=%b err=%b dat=%h lat=%0d tail=%b, required ack=%b err=%b dat=%h lat=%0d tail=0",
                         i, r_got, r_ack, r_err, r_dat, r_lat, r_tail, !x.err, x.err, x.dat, x.lat);
            end
        end
    endtask

    task automatic test_reset_wait;
        op_t ops [3] = '{
            '{1, 1'b1, 32'h8000_0040, 32'hCAFEF00D, 4'hF},
            '{1, 1'b0, 32'h8000_0040, 32'h0,        4'hF},
            '{1, 1'b0, 32'h8000_0040, 32'h0,        4'hF}
        };
        int bad = 0;
        for (int i = 0; i < 3; i++) begin
            exp_t x;
            if (i == 2) begin
                @(negedge clk);
                cyc = 4'b0010; stb = 1'b1; we = 1'b1; adr = 32'h8000_0040; wdat = 32'h55555555; sel = 4'hF;
                @(negedge clk);
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0; cyc = '0; stb = 1'b0;
                mdo = '{default: '0};
                repeat (20) begin
                    @(negedge clk);
                    if (ack[1] !== 1'b0 || err[1] !== 1'b0 || dat_o[1] !== 32'h0) bad++;
                end
                checks++;
                if (bad != 0) begin
                    errors++;
                    $display("FAIL reset_wait: bad cycles=%0d dat=%h, required 0 and 00000000", bad, dat_o[1]);
                end
            end
            step(ops[i]);
            x = sb.pop_front();
            checks++;
            if (!r_got || r_ack !== !x.err || r_err !== x.err || r_dat !== x.dat || r_lat != x.lat || r_tail !== 1'b0) begin
                errors++;
                $display("FAIL reset_wait[%0d]: got=%b ack=%b err=%b dat=%h lat=%0d tail=%b, required ack=%b err=%b dat=%h lat=%0d tail=0",
                         i, r_got, r_ack, r_err, r_dat, r_lat, r_tail, !x.err, x.err, x.dat, x.lat);
            end
        end
    endtask

    // A read held high through RESP restarts every 3+WAIT_STATES cycles.
    task automatic test_back_to_back;
        for (int k = 0; k < 3; k++) begin
            exp_t x;
            x.err = 1'b0;
            x.dat = mm[4];
            x.lat = 3 + 4 * k;
            sb.push_back(x);
            resp_exp++;
        end
        mdo[0] = mm[4];
        @(negedge clk);
        cyc = 4'b0001; stb = 1'b1; we = 1'b0; adr = 32'h8000_0010; sel = 4'hF;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (ack[0] || err[0]) begin
                exp_t x;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_extra: response at cycle %0d, required none", k);
                end else begin
                    x = sb.pop_front();
                    if (ack[0] !== 1'b1 || dat_o[0] !== x.dat || k != x.lat) begin
                        errors++;
                        $display("FAIL b2b: ack=%b dat=%h cycle=%0d, required ack=1 dat=%h cycle=%0d", ack[0], dat_o[0], k, x.dat, x.lat);
                    end
                end
            end
        end
        cyc = '0; stb = 1'b0;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL b2b_missing: outstanding=%0d, required 0", sb.size());
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random;
        logic [31:0] bad_adr [4] = '{32'h7FFF_FFFC, 32'h8000_1000, 32'h8000_0101, 32'hFFFF_FFFC};
        for (int i = -24; i < 100; i++) begin
            op_t o;
            exp_t x;
            int k;
            k = i < 0 ? (i + 24) / 8 : int'($urandom_range(0, 2));
            o.d = k == 0 ? 2 : k == 1 ? 0 : 3;
            o.w = i < 0 ? 1'b1 : 1'($urandom_range(0, 1));
            o.a = i < 0 ? 32'h8000_0100 + 32'(4 * ((i + 24) % 8))
                : $urandom_range(0, 9) == 0 ? bad_adr[$urandom_range(0, 3)]
                : 32'h8000_0100 + 32'(4 * $urandom_range(0, 7));
            o.v = $urandom;
            o.s = i < 0 ? 4'hF : 4'($urandom_range(0, 15));
            step(o);
            x = sb.pop_front();
            checks++;
            if (!r_got || r_ack !== !x.err || r_err !== x.err || r_dat !== x.dat || r_lat != x.lat || r_tail !== 1'b0) begin
                errors++;
                $display("FAIL random[%0d] d=%0d adr=%h: got=%b ack=%b err=%b dat=%h lat=%0d tail=%b, required ack=%b err=%b dat=%h lat=%0d tail=0",
                         i, o.d, o.a, r_got, r_ack, r_err, r_dat, r_lat, r_tail, !x.err, x.err, x.dat, x.lat);
            end
        end
    endtask

    initial begin
        test_reset;
        test_rw;
        test_invalid;
        test_abort;
        test_reset_wait;
        test_back_to_back;
        test_random;
        repeat (3) @(negedge clk);
        checks++;
        if (resp_seen != resp_exp) begin
            errors++;
            $display("FAIL resp_count: seen=%0d, required %0d", resp_seen, resp_exp);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/wb_mem_slave.md
WB_MEM_SLAVE -- requirements
Module: wb_mem_slave

Interface
REQ-001 Parameter BASE_ADDR, default 32'h8000_0000, is the byte address of memory word 0.
REQ-002 Parameter ADDR_WIDTH, default 32, is the Wishbone address width.
REQ-003 Parameter DATA_WIDTH, default 32, is the Wishbone data width; the byte-lane count is DATA_WIDTH/8.
REQ-004 Parameter DEPTH_WORDS, default 1024, is the memory depth in words and SHALL be a power of two.
REQ-005 Parameter WAIT_STATES, default 1, is the number of extra cycles inserted before the response; the legal range is 0..15.
REQ-006 clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-007 reset  input  1  is a synchronous, active-high reset.
REQ-008 wb_cyc_i  input  1  is the bus-cycle-valid signal from the master.
REQ-009 wb_stb_i  input  1  is the strobe from the master.
REQ-010 wb_we_i  input  1  selects the access type: 1 = write, 0 = read.
REQ-011 wb_adr_i  input  ADDR_WIDTH  is the byte address.
REQ-012 wb_dat_i  input  DATA_WIDTH  is the write data.
REQ-013 wb_sel_i  input  DATA_WIDTH/8  is the byte-lane enable; bit i enables bits [8i+7:8i].
REQ-014 wb_dat_o  output  DATA_WIDTH  is the read data.
REQ-015 wb_ack_o  output  1  signals normal completion and SHALL be a registered output.
REQ-016 wb_err_o  output  1  signals error completion and SHALL be a registered output.

Function
REQ-017 The block SHALL implement a three-state FSM with states IDLE, WAIT and RESP.
REQ-018 In IDLE with wb_cyc_i=1 and wb_stb_i=1 at a rising edge, the block SHALL latch adr, we, sel and dat, load wait_cnt=WAIT_STATES, and enter WAIT.
REQ-019 In WAIT with wait_cnt>0, the block SHALL decrement wait_cnt each edge.
REQ-020 In WAIT with wait_cnt=0, the block SHALL perform the access and enter RESP on that edge.
REQ-021 Latency: ack or err SHALL first be visible 2+WAIT_STATES cycles after the edge that sampled the request.
REQ-022 RESP SHALL last exactly one cycle: exactly one of wb_ack_o or wb_err_o is high, and the FSM returns to IDLE on the next edge.
REQ-023 wb_ack_o and wb_err_o SHALL never be high simultaneously, and SHALL be low in IDLE and WAIT.
REQ-024 Decode: word index = (adr - BASE_ADDR) >> 2.
REQ-025 An access is valid when adr >= BASE_ADDR, index < DEPTH_WORDS, and adr[1:0] = 2'b00.
REQ-026 An invalid access (out-of-range or misaligned) SHALL assert wb_err_o in RESP, perform no memory write, and leave wb_dat_o unchanged.
REQ-027 A valid write SHALL update only the byte lanes enabled by sel.
REQ-028 A valid write with sel=0 SHALL still be acknowledged and leave memory unchanged.
REQ-029 A write SHALL leave wb_dat_o unchanged.
REQ-030 A valid read SHALL load wb_dat_o with the full word, regardless of sel.
REQ-031 wb_dat_o SHALL hold its value until the next valid read.
REQ-032 Abort: if wb_cyc_i or wb_stb_i is low at any edge in WAIT, the FSM SHALL return to IDLE with no access performed and no ack or err.
REQ-033 In RESP the inputs SHALL be ignored.
REQ-034 A request still asserted after RESP SHALL be sampled in IDLE as a new transfer.
REQ-035 The minimum spacing between two transfer starts SHALL be 3+WAIT_STATES cycles.
REQ-036 A read of a word written earlier SHALL return the merged byte-lane result of all prior writes.
REQ-037 Memory contents are undefined until written and SHALL NOT be cleared by reset.

Reset
REQ-038 On reset the block SHALL enter IDLE and drive wb_ack_o=0, wb_err_o=0, wb_dat_o=0, with wait_cnt and the latched request fields set to 0.
REQ-039 Reset asserted in WAIT SHALL drop the pending access: no write occurs and no response is issued.
REQ-040 Reset asserted in RESP SHALL deassert ack and err on the following cycle.
REQ-041 Reset SHALL take priority over a request sampled at the same edge.

Verification
REQ-042 Write 0xDEADBEEF to 0x8000_0010 with sel=4'hF, then read 0x8000_0010 -> ack on each transfer, read data = 0xDEADBEEF, with WAIT_STATES=1 giving ack 3 cycles after the request is sampled.
REQ-043 Write 0x11223344 with sel=4'hF, then write 0xAABBCCDD with sel=4'b0101, then read the same word -> 0x11BB33DD.
REQ-044 Read 0x7FFF_FFFC, read 0x8000_1000 (DEPTH_WORDS=1024), and read 0x8000_0002 -> err for one cycle on each, ack=0, wb_dat_o unchanged.
REQ-045 Start a write with WAIT_STATES=3 and drop stb after 1 cycle in WAIT -> no ack or err, word unchanged on readback, and the next request is served normally.
REQ-046 Assert reset during WAIT of a write of 0x5555_5555 -> ack=0, err=0, wb_dat_o=0, and readback shows the old value.
REQ-047 Run 100 random back-to-back accesses against a reference model with WAIT_STATES in {0, 1, 15} -> all read data matches, no ack/err overlap, and exactly one response per completed request.
